microwave_timer_ctrl: RTL and testbench

Sequencer for the microwave timer datapath. It consumes the coded keypad digits, their load strobe and the 1 Hz timebase. It holds a 4-digit BCD MM:SS setpoint and runs the cook/pause/done state machine. It drives the magnetron enable, the keypad enable and the time display digits.

---
 rtl/microwave_timer_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_microwave_timer_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer_ctrl.sv
// Microwave timer sequencer: edge-detects the keypad strobe, buttons and the
// 1 Hz timebase, holds a 4-digit BCD MM:SS setpoint and runs the
// SETUP / COOK / PAUSE / DONE state machine. Only one event acts per clock;
// lower-priority events arriving in the same cycle are dropped.
module microwave_timer_ctrl #(
  parameter int DONE_SECONDS = 3,
  parameter int MAX_DIGIT    = 9
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  output logic       enn,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       done
);

  typedef enum logic [1:0] {
    S_SETUP = 2'd0,
    S_COOK  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] min_tens_q, min_tens_d, min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic       mag_on_q, mag_on_d, done_q, done_d, enn_q, enn_d;
  logic       loadn_h_q, startn_h_q, stopn_h_q, clearn_h_q, pgt_h_q;

  logic       key_ev, start_ev, stop_ev, clr_ev, tick;
  logic       door_w, clr_w, stop_w, start_w, tick_w, key_w;
  logic [3:0] so_dec, st_dec, mo_dec, mt_dec;
  logic       b_so, b_st, b_mo, dec_zero, time_nz, digit_ok;

  // Falling edges of the active-low inputs, rising edge of the timebase.
  assign key_ev   = loadn_h_q  & ~loadn;
  assign start_ev = startn_h_q & ~startn;
  assign stop_ev  = stopn_h_q  & ~stopn;
  assign clr_ev   = clearn_h_q & ~clearn;
  assign tick     = ~pgt_h_q & pgt_1Hz;
  assign digit_ok = (int'(D) <= MAX_DIGIT);
  assign time_nz  = |{min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};

  // Single winning event: door open > clear > stop > start > tick > key.
  always_comb begin
    door_w  = ~door_closed;
    clr_w   = ~door_w & clr_ev;
    stop_w  = ~door_w & ~clr_ev & stop_ev;
    start_w = ~door_w & ~clr_ev & ~stop_ev & start_ev;
    tick_w  = ~door_w & ~clr_ev & ~stop_ev & ~start_ev & tick;
    key_w   = ~door_w & ~clr_ev & ~stop_ev & ~start_ev & ~tick & key_ev;
  end

  // One-second BCD decrement; seconds tens borrow from 0 reloads 5.
  always_comb begin
    b_so   = (sec_ones_q == 4'd0);
    so_dec = b_so ? 4'd9 : (sec_ones_q - 4'd1);
    b_st   = b_so & (sec_tens_q == 4'd0);
    if (b_so) begin
      st_dec = (sec_tens_q == 4'd0) ? 4'd5 : (sec_tens_q - 4'd1);
    end else begin
      st_dec = sec_tens_q;
    end
    b_mo = b_st & (min_ones_q == 4'd0);
    if (b_st) begin
      mo_dec = (min_ones_q == 4'd0) ? 4'd9 : (min_ones_q - 4'd1);
    end else begin
      mo_dec = min_ones_q;
    end
    mt_dec   = b_mo ? (min_tens_q - 4'd1) : min_tens_q;
    dec_zero = ({mt_dec, mo_dec, st_dec, so_dec} == 16'h0000);
  end

  // Next-state, setpoint and done-counter logic.
  always_comb begin
    state_d    = state_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    dcnt_d     = dcnt_q;
    case (state_q)
      S_SETUP: begin
        if (clr_w) begin
          {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} = 16'h0000;
        end else if (start_w) begin
          state_d = time_nz ? S_COOK : S_SETUP;
        end else if (key_w && digit_ok) begin
          min_tens_d = min_ones_q;
          min_ones_d = sec_tens_q;
          sec_tens_d = sec_ones_q;
          sec_ones_d = D;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_COOK: begin
        if (door_w || clr_w || stop_w) begin
          state_d = S_PAUSE;
        end else if (tick_w) begin
          {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} = {mt_dec, mo_dec, st_dec, so_dec};
          if (dec_zero) begin
            state_d = S_DONE;
            dcnt_d  = 8'(DONE_SECONDS);
          end else begin
            state_d = S_COOK;
          end
        end else begin
          state_d = S_COOK;
        end
      end
      S_PAUSE: begin
        if (clr_w) begin
          state_d = S_SETUP;
          {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} = 16'h0000;
        end else if (start_w) begin
          state_d = S_COOK;
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_DONE: begin
        if (door_w || clr_w || stop_w || start_w) begin
          state_d = S_SETUP;
        end else if (dcnt_q == 8'd0) begin
          state_d = S_SETUP;
        end else if (tick_w) begin
          dcnt_d  = dcnt_q - 8'd1;
          state_d = (dcnt_q == 8'd1) ? S_SETUP : S_DONE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_SETUP;
      end
    endcase
  end

  // Output flops are loaded from the state being entered.
  always_comb begin
    mag_on_d = (state_d == S_COOK);
    done_d   = (state_d == S_DONE);
    enn_d    = ~((state_d == S_SETUP) || (state_d == S_PAUSE));
  end

  // State, setpoint, edge-detect history and registered outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= S_SETUP;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      dcnt_q     <= 8'd0;
      mag_on_q   <= 1'b0;
      done_q     <= 1'b0;
      enn_q      <= 1'b0;
      loadn_h_q  <= 1'b1;
      startn_h_q <= 1'b1;
      stopn_h_q  <= 1'b1;
      clearn_h_q <= 1'b1;
      pgt_h_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      dcnt_q     <= dcnt_d;
      mag_on_q   <= mag_on_d;
      done_q     <= done_d;
      enn_q      <= enn_d;
      loadn_h_q  <= loadn;
      startn_h_q <= startn;
      stopn_h_q  <= stopn;
      clearn_h_q <= clearn;
      pgt_h_q    <= pgt_1Hz;
    end
  end

  // The door gate is combinational so an opening door kills the magnetron at once.
  assign mag_on   = mag_on_q & door_closed;
  assign done     = done_q;
  assign enn      = enn_q;
  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed scenarios with literal
// expectations, then randomized stimulus, all outputs compared every cycle
// against a behavioural model that keeps the time as an integer MMSS value.
module tb_microwave_timer_ctrl;

  localparam int DONE_S = 3;
  localparam int MAXD   = 9;
  localparam int ST_SETUP = 0, ST_COOK = 1, ST_PAUSE = 2, ST_DONE = 3;

  logic       clk = 1'b0;
  logic       clrn, loadn, pgt_1Hz, startn, stopn, clearn, door_closed;
  logic [3:0] D;
  logic       enn, mag_on, done;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

  int tests = 0;
  int fails = 0;

  // behavioural model state
  int m_state, m_t, m_cnt;
  bit h_load, h_start, h_stop, h_clr, h_pgt;

  microwave_timer_ctrl #(.DONE_SECONDS(DONE_S), .MAX_DIGIT(MAXD)) dut (
    .clk(clk), .clrn(clrn), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .startn(startn), .stopn(stopn), .clearn(clearn), .door_closed(door_closed),
    .enn(enn), .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .mag_on(mag_on), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %05h expected %05h (enn,mag,done,MMSS) at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {13'd0, enn, mag_on, done, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic chk_out(input string name, input logic e_enn, input logic e_mag,
                         input logic e_done, input logic [15:0] e_dig);
    chk(name, dut_vec(), {13'd0, e_enn, e_mag, e_done, e_dig});
  endtask

  function automatic logic [31:0] model_vec();
    int  mm, ss;
    bit  e_enn, e_mag, e_done;
    mm     = m_t / 100;
    ss     = m_t % 100;
    e_enn  = !(m_state == ST_SETUP || m_state == ST_PAUSE);
    e_mag  = (m_state == ST_COOK) && door_closed;
    e_done = (m_state == ST_DONE);
    return {13'd0, e_enn, e_mag, e_done, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_reset();
    m_state = ST_SETUP; m_t = 0; m_cnt = 0;
    h_load = 1; h_start = 1; h_stop = 1; h_clr = 1; h_pgt = 1;
  endtask

  // One clock of the specification's rules; w is the single winning event.
  task automatic model_step();
    bit k, s, p, c, t;
    int w;
    k = h_load && !loadn;  s = h_start && !startn;  p = h_stop && !stopn;
    c = h_clr && !clearn;  t = !h_pgt && pgt_1Hz;
    h_load = loadn; h_start = startn; h_stop = stopn; h_clr = clearn; h_pgt = pgt_1Hz;
    if (!door_closed) w = 1;
    else if (c) w = 2;
    else if (p) w = 3;
    else if (s) w = 4;
    else if (t) w = 5;
    else if (k) w = 6;
    else w = 0;
    case (m_state)
      ST_SETUP: begin
        if (w == 2) m_t = 0;
        else if (w == 4 && m_t != 0) m_state = ST_COOK;
        else if (w == 6 && int'(D) <= MAXD) m_t = (m_t % 1000) * 10 + int'(D);
      end
      ST_COOK: begin
        if (w >= 1 && w <= 3) m_state = ST_PAUSE;
        else if (w == 5) begin
          m_t = (m_t % 100 != 0) ? m_t - 1 : m_t - 100 + 59;
          if (m_t == 0) begin m_state = ST_DONE; m_cnt = DONE_S; end
        end
      end
      ST_PAUSE: begin
        if (w == 2) begin m_t = 0; m_state = ST_SETUP; end
        else if (w == 4) m_state = ST_COOK;
      end
      default: begin
        if (w >= 1 && w <= 4) m_state = ST_SETUP;
        else if (m_cnt == 0) m_state = ST_SETUP;
        else if (w == 5) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_state = ST_SETUP;
        end
      end
    endcase
  endtask

  // Compare process: advance model on each rising edge, check 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      if (!clrn) model_reset();
      else model_step();
      #1;
      chk("cycle", dut_vec(), model_vec());
    end
  end

  task automatic key(input logic [3:0] d);
    @(negedge clk); D = d; loadn = 1'b0;
    @(negedge clk); loadn = 1'b1;
  endtask

  task automatic press(input int which);
    @(negedge clk);
    if (which == 0) startn = 1'b0; else if (which == 1) stopn = 1'b0; else clearn = 1'b0;
    @(negedge clk);
    startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
  endtask

  task automatic tick1();
    @(negedge clk); pgt_1Hz = 1'b1;
    @(negedge clk); pgt_1Hz = 1'b0;
  endtask

  initial begin
    clrn = 1'b0; loadn = 1'b1; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; pgt_1Hz = 1'b0; D = 4'd0;
    repeat (3) @(negedge clk);
    chk_out("reset", 1'b0, 1'b0, 1'b0, 16'h0000);
    clrn = 1'b1;

    // keypad entry and shifting
    key(4'd1); key(4'd3); key(4'd0);
    chk_out("keys_130", 1'b0, 1'b0, 1'b0, 16'h0130);
    key(4'd12);
    chk_out("bad_digit", 1'b0, 1'b0, 1'b0, 16'h0130);
    key(4'd5);
    chk_out("fifth_digit", 1'b0, 1'b0, 1'b0, 16'h1305);

    // 00:05 cook to done, then done hold
    press(2); key(4'd0); key(4'd5);
    press(0);
    chk_out("cook_start", 1'b1, 1'b1, 1'b0, 16'h0005);
    for (int i = 4; i >= 1; i--) begin
      tick1();
      chk_out("countdown", 1'b1, 1'b1, 1'b0, {12'h000, 4'(i)});
    end
    tick1();
    chk_out("reach_done", 1'b1, 1'b0, 1'b1, 16'h0000);
    tick1(); tick1();
    chk_out("done_hold", 1'b1, 1'b0, 1'b1, 16'h0000);
    tick1();
    chk_out("done_exit", 1'b0, 1'b0, 1'b0, 16'h0000);

    // borrows
    key(4'd1); key(4'd0); key(4'd0); press(0); tick1();
    chk_out("min_borrow", 1'b1, 1'b1, 1'b0, 16'h0059);
    press(1);
    chk_out("stop_pause", 1'b0, 1'b0, 1'b0, 16'h0059);
    press(2);
    key(4'd1); key(4'd0); key(4'd0); key(4'd0); press(0); tick1();
    chk_out("ten_borrow", 1'b1, 1'b1, 1'b0, 16'h0959);
    press(2);
    chk_out("clr_as_stop", 1'b0, 1'b0, 1'b0, 16'h0959);
    press(2);
    chk_out("pause_clear", 1'b0, 1'b0, 1'b0, 16'h0000);

    // door opening during cook
    key(4'd1); key(4'd0); press(0);
    @(negedge clk); door_closed = 1'b0; #1;
    chk_out("door_gate", 1'b1, 1'b0, 1'b0, 16'h0010);
    @(negedge clk);
    chk_out("door_pause", 1'b0, 1'b0, 1'b0, 16'h0010);
    tick1(); tick1();
    chk_out("pause_hold", 1'b0, 1'b0, 1'b0, 16'h0010);
    @(negedge clk); door_closed = 1'b1;
    press(0);
    chk_out("resume", 1'b1, 1'b1, 1'b0, 16'h0010);
    tick1();
    chk_out("resume_tick", 1'b1, 1'b1, 1'b0, 16'h0009);
    press(1); press(2);

    // simultaneous events
    key(4'd3);
    @(negedge clk); startn = 1'b0; pgt_1Hz = 1'b1;
    @(negedge clk); startn = 1'b1; pgt_1Hz = 1'b0;
    chk_out("start_tick", 1'b1, 1'b1, 1'b0, 16'h0003);
    press(1);
    @(negedge clk); startn = 1'b0; clearn = 1'b0;
    @(negedge clk); startn = 1'b1; clearn = 1'b1;
    chk_out("clr_start", 1'b0, 1'b0, 1'b0, 16'h0000);
    key(4'd4);
    chk_out("setup_after", 1'b0, 1'b0, 1'b0, 16'h0004);

    // asynchronous reset mid-cook
    press(2); key(4'd7); press(0);
    chk_out("cook_07", 1'b1, 1'b1, 1'b0, 16'h0007);
    @(negedge clk); #2 clrn = 1'b0; #1;
    chk_out("async_reset", 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk); clrn = 1'b1;

    // held start button gives one event only
    key(4'd2);
    @(negedge clk); startn = 1'b0;
    repeat (100) @(negedge clk);
    chk_out("start_held", 1'b1, 1'b1, 1'b0, 16'h0002);
    press(1);
    repeat (5) @(negedge clk);
    chk_out("single_start", 1'b0, 1'b0, 1'b0, 16'h0002);
    startn = 1'b1;
    press(2);

    // randomized phase
    repeat (4000) begin
      @(negedge clk);
      clrn        = ($urandom_range(0, 299) != 0);
      door_closed = ($urandom_range(0, 19) != 0);
      loadn       = ($urandom_range(0, 2) != 0);
      D           = 4'($urandom_range(0, 15));
      startn      = ($urandom_range(0, 5) != 0);
      stopn       = ($urandom_range(0, 24) != 0);
      clearn      = ($urandom_range(0, 39) != 0);
      pgt_1Hz     = ($urandom_range(0, 1) != 0);
    end
    @(negedge clk);
    clrn = 1'b1; loadn = 1'b1; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
